// File: rtl/wasca_spi_sync_tx.sv
// wasca_spi_sync_tx
//   Avalon-MM slave driving the outbound sync line to the SPI peer.
//   Software sets a static idle level or fires a timed pulse of
//   programmable length, then polls busy/done/overrun. A guard gap after
//   every pulse keeps consecutive pulses visibly separated at the peer.
//
//   Optional feature macro: SPI_SYNC_TX_IRQ_EN (adds irq port and irq_en).
//
// Ports:
//   clk        - clock
//   reset_n    - asynchronous, active-low reset
//   address    - word register select (0 DATA, 1 PULSE_LEN, 2 CTRL/STATUS, 3 COUNT)
//   chipselect - slave select
//   write_n    - active-low write strobe, qualified by chipselect
//   writedata  - write data
//   readdata   - registered read data, 1-cycle latency, no read strobe
//   out_port   - registered sync line to the SPI peer
//   irq        - registered done & irq_en (only with SPI_SYNC_TX_IRQ_EN)
`timescale 1ns/1ps

module wasca_spi_sync_tx #(
    parameter int unsigned LEN_W      = 16,
    parameter int unsigned LEN_RST    = 4,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
`ifdef SPI_SYNC_TX_IRQ_EN
    output logic        irq,
`endif
    output logic        out_port
);

    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [LEN_W-1:0]   pulse_len;
    logic [LEN_W-1:0]   cnt, cnt_nxt;
    logic [GAP_W-1:0]   gap_cnt, gap_nxt;
    logic               idle_level;
    logic               done, done_nxt;
    logic               overrun, ovr_nxt;
    logic               irq_en_bit;
    logic               wr_en;
    logic               ctrl_wr;
    logic               trigger;
    logic               busy;
    logic [LEN_W-1:0]   load_len;
    logic [31:0]        rd_nxt;
    logic               unused_wdata;

    assign wr_en    = chipselect & ~write_n;
    assign ctrl_wr  = wr_en && (address == 2'd2);
    assign trigger  = ctrl_wr && writedata[0];
    assign busy     = (state != ST_IDLE);
    assign load_len = (pulse_len == '0) ? LEN_W'(1) : pulse_len;
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            gap_cnt <= '0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            gap_cnt <= gap_nxt;
            done    <= done_nxt;
            overrun <= ovr_nxt;
        end
    end

    // Flag clear is applied first so a set in the same cycle overrides it.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        gap_nxt   = gap_cnt;
        done_nxt  = done;
        ovr_nxt   = overrun;

        if (ctrl_wr && writedata[1]) begin
            done_nxt = 1'b0;
            ovr_nxt  = 1'b0;
        end

        case (state)
            ST_IDLE: begin
                if (trigger) begin
                    state_nxt = ST_PULSE;
                    cnt_nxt   = load_len;
                end
            end
            ST_PULSE: begin
                if (trigger) ovr_nxt = 1'b1;
                if (cnt <= LEN_W'(1)) begin
                    state_nxt = ST_GAP;
                    cnt_nxt   = '0;
                    gap_nxt   = GAP_W'(GAP_CYCLES);
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt - LEN_W'(1);
                end
            end
            ST_GAP: begin
                if (trigger) ovr_nxt = 1'b1;
                if (gap_cnt <= GAP_W'(1)) begin
                    state_nxt = ST_IDLE;
                    gap_nxt   = '0;
                end else begin
                    gap_nxt = gap_cnt - GAP_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
                gap_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_level <= 1'b0;
            pulse_len  <= LEN_W'(LEN_RST);
        end else if (wr_en) begin
            if (address == 2'd0) idle_level <= writedata[0];
            if (address == 2'd1) pulse_len  <= writedata[LEN_W-1:0];
        end
    end

    // A pulse in flight is an inversion of whatever the idle level currently is.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) out_port <= 1'b0;
        else          out_port <= idle_level ^ (state == ST_PULSE);
    end

`ifdef SPI_SYNC_TX_IRQ_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en_bit <= 1'b0;
            irq        <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en_bit <= writedata[2];
            irq <= done & irq_en_bit;
        end
    end
`else
    assign irq_en_bit = 1'b0;
`endif

    always_comb begin
        rd_nxt = '0;
        case (address)
            2'd0: rd_nxt[0] = out_port;
            2'd1: rd_nxt[LEN_W-1:0] = pulse_len;
            2'd2: rd_nxt[3:0] = {irq_en_bit, overrun, done, busy};
            2'd3: rd_nxt[LEN_W-1:0] = cnt;
            default: rd_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= rd_nxt;
    end

endmodule
